bayer_block_sampler: RTL and testbench

- Sits directly downstream of the 2x2 interpolate stage in the camera pipeline.
- Tracks raw-pixel position within each frame.
- Keeps only the averaged sample whose 2x2 window covers one complete even-aligned Bayer quad (odd column, odd row). This yields a half-resolution 12-bit grey stream with coordinates and frame/line markers for the next stage (filter / frame-buffer writer).

---
 rtl/bayer_block_sampler_pkg.sv | 14 +
 rtl/bayer_block_sampler_raw_pixel_counter.sv | 49 ++++
 rtl/bayer_block_sampler.sv | 108 ++++++++++
 tb/tb_bayer_block_sampler.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bayer_block_sampler_pkg.sv
// Shared types for the Bayer block sampler and its raw-pixel counter.
package bayer_sampler_pkg;

  // Frame tracking state: waiting for a start-of-frame, or walking a frame.
  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Pixel width shared with the upstream 2x2 interpolate stage.
  localparam int PIX_W = 12;
  typedef logic [PIX_W-1:0] pixel_t;

endpackage

// File: rtl/bayer_block_sampler_raw_pixel_counter.sv
// Raw pixel position counter: x/y with row wrap, end-of-row / end-of-frame
// flags and a synchronous restart that consumes the start-of-frame pixel.
module raw_pixel_counter #(
  parameter int ROW_LENGTH = 1280,
  parameter int ROW_COUNT  = 960,
  parameter int XRW        = 11,
  parameter int YRW        = 10
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_restart,
  input  logic           i_advance,
  output logic [XRW-1:0] o_x,
  output logic [YRW-1:0] o_y,
  output logic           o_last_in_row,
  output logic           o_last_in_frame
);

  localparam logic [XRW-1:0] X_LAST = XRW'(ROW_LENGTH - 1);
  localparam logic [YRW-1:0] Y_LAST = YRW'(ROW_COUNT - 1);

  logic [XRW-1:0] x;
  logic [YRW-1:0] y;

  assign o_x             = x;
  assign o_y             = y;
  assign o_last_in_row   = (x == X_LAST);
  assign o_last_in_frame = (x == X_LAST) && (y == Y_LAST);

  // Restart lands on (1,0) because the restarting pixel itself is (0,0);
  // otherwise step along the row and wrap into the next row.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x <= '0;
      y <= '0;
    end else if (i_restart) begin
      x <= XRW'(1);
      y <= '0;
    end else if (i_advance) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + YRW'(1);
      end else begin
        x <= x + XRW'(1);
      end
    end
  end

endmodule

// File: rtl/bayer_block_sampler.sv
// Keeps one interpolated sample per complete Bayer quad (odd x, odd y) and
// emits a half-resolution grey stream with coordinates and frame markers.
module bayer_block_sampler
  import bayer_sampler_pkg::*;
#(
  parameter int ROW_LENGTH = 1280,
  parameter int ROW_COUNT  = 960,
  parameter int XW         = $clog2(ROW_LENGTH / 2),
  parameter int YW         = $clog2(ROW_COUNT / 2)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [11:0]   i_data,
  input  logic          i_valid,
  input  logic          i_sof,
  input  logic          i_clr_err,
  output logic [11:0]   o_data,
  output logic          o_valid,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_sof,
  output logic          o_eol,
  output logic          o_eof,
  output logic          o_frame_err
);

  // Raw counters carry one extra LSB below the output coordinate.
  localparam int XRW = XW + 1;
  localparam int YRW = YW + 1;

  state_t         state, next_state;
  logic [XRW-1:0] x;
  logic [YRW-1:0] y;
  logic           last_in_row, last_in_frame;
  logic           restart, advance, capture, err_event;

  raw_pixel_counter #(
    .ROW_LENGTH (ROW_LENGTH),
    .ROW_COUNT  (ROW_COUNT),
    .XRW        (XRW),
    .YRW        (YRW)
  ) u_counter (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_restart       (restart),
    .i_advance       (advance),
    .o_x             (x),
    .o_y             (y),
    .o_last_in_row   (last_in_row),
    .o_last_in_frame (last_in_frame)
  );

  // Frame state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next state, counter control and capture decision; an SOF always wins and
  // is never itself captured since it sits at x=0.
  always_comb begin
    next_state = state;
    restart    = 1'b0;
    advance    = 1'b0;
    capture    = 1'b0;
    err_event  = 1'b0;
    if (i_valid && i_sof) begin
      restart    = 1'b1;
      next_state = ACTIVE;
      err_event  = (state == ACTIVE);
    end else if (i_valid && state == ACTIVE) begin
      advance = 1'b1;
      capture = x[0] && y[0];
      if (last_in_frame) next_state = IDLE;
    end
  end

  // Output registers: markers pulse with o_valid, data/coords hold until the next capture.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_sof   <= 1'b0;
      o_eol   <= 1'b0;
      o_eof   <= 1'b0;
      o_data  <= '0;
      o_x     <= '0;
      o_y     <= '0;
    end else begin
      o_valid <= capture;
      o_sof   <= capture && (x == XRW'(1)) && (y == YRW'(1));
      o_eol   <= capture && last_in_row;
      o_eof   <= capture && last_in_frame;
      if (capture) begin
        o_data <= i_data;
        o_x    <= x[XRW-1:1];
        o_y    <= y[YRW-1:1];
      end
    end
  end

  // Sticky frame error; a new error takes precedence over a clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       o_frame_err <= 1'b0;
    else if (err_event) o_frame_err <= 1'b1;
    else if (i_clr_err) o_frame_err <= 1'b0;
  end

endmodule

// File: tb/tb_bayer_block_sampler.sv
// Randomised self-checking bench for bayer_block_sampler on an 8x4 raw frame.
module tb_bayer_block_sampler;

  localparam int RL   = 8;
  localparam int RC   = 4;
  localparam int NPIX = RL * RC;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [11:0] i_data = '0;
  logic        i_valid = 1'b0;
  logic        i_sof = 1'b0;
  logic        i_clr_err = 1'b0;
  logic [11:0] o_data;
  logic        o_valid;
  logic [1:0]  o_x;
  logic [0:0]  o_y;
  logic        o_sof, o_eol, o_eof, o_frame_err;

  int checks = 0;
  int fails  = 0;

  bayer_block_sampler #(.ROW_LENGTH(RL), .ROW_COUNT(RC)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .i_sof       (i_sof),
    .i_clr_err   (i_clr_err),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_x         (o_x),
    .o_y         (o_y),
    .o_sof       (o_sof),
    .o_eol       (o_eol),
    .o_eof       (o_eof),
    .o_frame_err (o_frame_err)
  );

  always #5 i_clk = ~i_clk;

  // Observation vector: {valid, sof, eol, eof, err, data[12], x[2], y[1]}
  typedef logic [19:0] vec_t;

  // Reference model: frame position as a linear raw-pixel index (x + RL*y).
  bit          m_in_frame;
  int          m_pos;
  bit          m_err;
  logic [11:0] m_data;
  logic [1:0]  m_x;
  logic [0:0]  m_y;

  function automatic vec_t observe();
    return {o_valid, o_sof, o_eol, o_eof, o_frame_err, o_data, o_x, o_y};
  endfunction

  task automatic model_reset();
    m_in_frame = 0; m_pos = 0; m_err = 0;
    m_data = '0; m_x = '0; m_y = '0;
  endtask

  // Drive one clock of stimulus, advance the model, return expected and observed.
  task automatic step_cycle(input bit v, input bit s, input bit c,
                            output vec_t exp_v, output vec_t obs_v);
    int cur;
    bit pix, err_ev, cap, e_sof, e_eol, e_eof;
    pix = 0; err_ev = 0; cur = 0;
    cap = 0; e_sof = 0; e_eol = 0; e_eof = 0;
    if (v && s) begin
      err_ev = m_in_frame; m_in_frame = 1; cur = 0; pix = 1;
    end else if (v && m_in_frame) begin
      cur = m_pos + 1; pix = 1;
    end
    i_valid = v; i_sof = s; i_clr_err = c;
    i_data = pix ? 12'(cur) : 12'($urandom_range(0, 4095));
    if (pix) begin
      m_pos = cur;
      if ((cur % RL) % 2 == 1 && (cur / RL) % 2 == 1) begin
        cap    = 1;
        m_data = 12'(cur);
        m_x    = 2'((cur % RL) / 2);
        m_y    = 1'((cur / RL) / 2);
        e_sof  = (cur == RL + 1);
        e_eol  = (cur % RL == RL - 1);
        e_eof  = (cur == NPIX - 1);
      end
      if (cur == NPIX - 1) m_in_frame = 0;
    end
    if (err_ev) m_err = 1;
    else if (c) m_err = 0;
    exp_v = {cap, e_sof, e_eol, e_eof, m_err, m_data, m_x, m_y};
    @(posedge i_clk); #1;
    obs_v = observe();
  endtask

  task automatic test_reset();
    vec_t obs;
    i_rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    obs = observe();
    checks++;
    if (obs !== '0) begin
      fails++;
      $display("FAIL reset_state: got %h expected 0", obs);
    end
    i_rst_n = 1'b1;
    $display("test_reset: outputs=%h", obs);
  endtask

  task automatic test_clean_frame();
    vec_t e, o;
    logic [11:0] seen[$];
    logic [11:0] table_v[8] = '{12'd9, 12'd11, 12'd13, 12'd15, 12'd25, 12'd27, 12'd29, 12'd31};
    for (int i = 0; i < NPIX + 3; i++) begin
      step_cycle(i < NPIX, i == 0, 1'b0, e, o);
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL clean_frame cycle %0d: got %h expected %h", i, o, e);
      end
      if (o_valid === 1'b1) seen.push_back(o_data);
    end
    checks++;
    if (seen.size() != 8) begin
      fails++;
      $display("FAIL clean_frame_count: got %0d pulses expected 8", seen.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (seen[k] !== table_v[k]) begin
          fails++;
          $display("FAIL clean_frame_data[%0d]: got %0d expected %0d", k, seen[k], table_v[k]);
        end
      end
    end
    $display("test_clean_frame: pulses=%0d", seen.size());
  endtask

  task automatic test_gaps();
    vec_t e, o;
    int sent, pulses, budget;
    sent = 0; pulses = 0; budget = 0;
    step_cycle(1'b1, 1'b1, 1'b0, e, o);
    sent = 1;
    checks++;
    if (o !== e) begin
      fails++;
      $display("FAIL gaps_sof: got %h expected %h", o, e);
    end
    while (sent < NPIX && budget < 500) begin
      bit v;
      v = 1'($urandom_range(0, 1));
      step_cycle(v, 1'b0, 1'b0, e, o);
      if (v) sent++;
      budget++;
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL gaps cycle %0d valid=%0d: got %h expected %h", budget, v, o, e);
      end
      if (o_valid === 1'b1) pulses++;
    end
    step_cycle(1'b0, 1'b0, 1'b0, e, o);
    checks++;
    if (sent != NPIX || pulses != 8 || o_valid !== 1'b0) begin
      fails++;
      $display("FAIL gaps_total: sent %0d pulses %0d expected %0d and 8", sent, pulses, NPIX);
    end
    $display("test_gaps: cycles=%0d pulses=%0d", budget, pulses);
  endtask

  task automatic test_pre_sof();
    vec_t e, o;
    for (int i = 0; i < 20; i++) begin
      step_cycle(1'b1, 1'b0, 1'b0, e, o);
      checks++;
      if (o !== e || o_valid !== 1'b0) begin
        fails++;
        $display("FAIL pre_sof cycle %0d: got %h expected %h", i, o, e);
      end
    end
    for (int i = 0; i < NPIX + 2; i++) begin
      step_cycle(i < NPIX, i == 0, 1'b0, e, o);
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL pre_sof_frame cycle %0d: got %h expected %h", i, o, e);
      end
    end
    checks++;
    if (o_frame_err !== 1'b0) begin
      fails++;
      $display("FAIL pre_sof_err: got %b expected 0", o_frame_err);
    end
    $display("test_pre_sof: frame_err=%b", o_frame_err);
  endtask

  task automatic test_abort();
    vec_t e, o;
    int eofs;
    eofs = 0;
    // Pixels 0..20, then SOF again on raw (5,2) = index 21, then a full frame.
    for (int i = 0; i < 21 + NPIX + 2; i++) begin
      bit s;
      s = (i == 0) || (i == 21);
      step_cycle(i < 21 + NPIX, s, 1'b0, e, o);
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL abort cycle %0d: got %h expected %h", i, o, e);
      end
      if (o_eof === 1'b1) eofs++;
    end
    checks++;
    if (o_frame_err !== 1'b1 || eofs != 1) begin
      fails++;
      $display("FAIL abort_err: err %b eofs %0d expected 1 and 1", o_frame_err, eofs);
    end
    step_cycle(1'b0, 1'b0, 1'b1, e, o);
    checks++;
    if (o_frame_err !== 1'b0 || o !== e) begin
      fails++;
      $display("FAIL abort_clear: got %h expected %h", o, e);
    end
    step_cycle(1'b0, 1'b0, 1'b0, e, o);
    $display("test_abort: eofs=%0d err_after_clear=%b", eofs, o_frame_err);
  endtask

  task automatic test_reset_mid();
    vec_t e, o;
    int pulses;
    pulses = 0;
    for (int i = 0; i < 11; i++) begin
      step_cycle(1'b1, i == 0, 1'b0, e, o);
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL reset_mid_pre cycle %0d: got %h expected %h", i, o, e);
      end
    end
    // Pixel (3,1) presented while reset is pulled low: its capture must be lost.
    i_valid = 1'b1; i_sof = 1'b0; i_data = 12'd11;
    i_rst_n = 1'b0;
    model_reset();
    @(posedge i_clk); #1;
    o = observe();
    checks++;
    if (o !== '0) begin
      fails++;
      $display("FAIL reset_mid_outputs: got %h expected 0", o);
    end
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step_cycle(1'b1, 1'b0, 1'b0, e, o);
      checks++;
      if (o !== e || o_valid !== 1'b0) begin
        fails++;
        $display("FAIL reset_mid_nosof cycle %0d: got %h expected %h", i, o, e);
      end
    end
    for (int i = 0; i < NPIX + 2; i++) begin
      step_cycle(i < NPIX, i == 0, 1'b0, e, o);
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL reset_mid_frame cycle %0d: got %h expected %h", i, o, e);
      end
      if (o_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 8) begin
      fails++;
      $display("FAIL reset_mid_count: got %0d pulses expected 8", pulses);
    end
    $display("test_reset_mid: pulses_after=%0d", pulses);
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_gaps();
    test_pre_sof();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
